// File: rtl/sram_bus_ctrl_if.sv
// Pipeline-side request/response bundle for the shared SRAM controller.
// The master is the CPU pipeline (fetch + MEM stage); the slave is the controller.
interface sram_bus_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        mem_req;
  logic        mem_we_n;
  logic [3:0]  mem_be_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        stall_req;

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we_n, mem_be_n, mem_addr, mem_wdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_req
  );

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we_n, mem_be_n, mem_addr, mem_wdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_req
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Arbiter and access sequencer for one asynchronous SRAM shared by the
// instruction-fetch and data ports: IDLE -> ACCESS (WAIT_CYCLES+1) -> DONE.
module sram_bus_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_mem_q, owner_mem_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_n_q, be_n_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_mem_q, last_mem_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;

  logic                grant_mem;
  logic                grant_if;
  logic                last_beat;

  // Byte-offset bits and bits above the SRAM word range carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_mem_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      be_n_q      <= 4'hF;
      wdata_q     <= 32'd0;
      last_mem_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      be_n_q      <= be_n_d;
      wdata_q     <= wdata_d;
      last_mem_q  <= last_mem_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_mem_d  = owner_mem_q;
    write_d      = write_q;
    addr_d       = addr_q;
    be_n_d       = be_n_q;
    wdata_d      = wdata_q;
    last_mem_d   = last_mem_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    grant_mem    = 1'b0;
    grant_if     = 1'b0;
    last_beat    = (cnt_q == LAST_CNT);
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_be_n    = 4'hF;
    sram_data_oe = 1'b0;

    case (state_q)
      IDLE: begin
        // MEM wins a tie unless it also won the previous grant.
        grant_mem = bus.mem_req & (~bus.if_req | ~last_mem_q);
        grant_if  = bus.if_req & ~grant_mem;
        if (grant_mem) begin
          owner_mem_d = 1'b1;
          last_mem_d  = 1'b1;
          write_d     = ~bus.mem_we_n;
          addr_d      = bus.mem_addr[ADDR_W+1:2];
          be_n_d      = bus.mem_be_n;
          wdata_d     = bus.mem_wdata;
        end else if (grant_if) begin
          owner_mem_d = 1'b0;
          last_mem_d  = 1'b0;
          write_d     = 1'b0;
          addr_d      = bus.if_addr[ADDR_W+1:2];
          be_n_d      = 4'b0000;
        end
        if (grant_mem | grant_if) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end
      end

      ACCESS: begin
        sram_ce_n = 1'b0;
        sram_be_n = be_n_q;
        if (write_q) begin
          // we_n rises one cycle before the bus is released so data holds past it.
          sram_data_oe = 1'b1;
          sram_we_n    = last_beat;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last_beat) begin
          state_d = DONE;
          if (!write_q) begin
            if (owner_mem_q) begin
              mem_rdata_d = sram_rdata;
            end else begin
              if_rdata_d = sram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign bus.if_ack    = (state_q == DONE) & ~owner_mem_q;
  assign bus.mem_ack   = (state_q == DONE) & owner_mem_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  // Stall drops in the ack cycle so the pipeline advances exactly on ack.
  assign bus.stall_req = rst & ((bus.mem_req & ~bus.mem_ack) |
                                (bus.if_req & ~bus.if_ack));

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Randomized bench for sram_bus_ctrl: two instances (WAIT_CYCLES 1 and 3) checked
// cycle by cycle against a transaction-level model of grants, timing and memory.
module tb_sram_bus_ctrl;

  localparam int W0 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;
  int     mode  = 0;
  bit     contend = 1'b0;

  logic        drvIfReq   [2];
  logic [31:0] drvIfAddr  [2];
  logic        drvMemReq  [2];
  logic        drvMemWeN  [2];
  logic [3:0]  drvMemBeN  [2];
  logic [31:0] drvMemAddr [2];
  logic [31:0] drvMemWdata[2];

  logic        oIfAck  [2];
  logic        oMemAck [2];
  logic        oStall  [2];
  logic        oCeN    [2];
  logic        oOeN    [2];
  logic        oWeN    [2];
  logic        oDoe    [2];
  logic [3:0]  oBeN    [2];
  logic [19:0] oAddr   [2];
  logic [31:0] oWdata  [2];
  logic [31:0] oIfRd   [2];
  logic [31:0] oMemRd  [2];
  logic [31:0] sramRd  [2];

  logic [31:0] sramMem [2][256];
  logic [31:0] refMem  [2][256];

  bit          busy      [2];
  longint      grantCyc  [2];
  bit          ownerMem  [2];
  bit          lastMem   [2];
  bit          tWrite    [2];
  logic [19:0] tAddr     [2];
  logic [3:0]  tBe       [2];
  logic [31:0] tWdata    [2];
  logic [31:0] eIfRd     [2];
  logic [31:0] eMemRd    [2];
  bit          seenIfAck [2];
  bit          seenMemAck[2];
  int          ifAckCnt  [2];
  int          memAckCnt [2];
  int          nAck      [2];
  longint      lastAckCyc[2];

  sram_bus_ctrl_if bus0 ();
  sram_bus_ctrl_if bus1 ();

  assign bus0.if_req    = drvIfReq[0];
  assign bus0.if_addr   = drvIfAddr[0];
  assign bus0.mem_req   = drvMemReq[0];
  assign bus0.mem_we_n  = drvMemWeN[0];
  assign bus0.mem_be_n  = drvMemBeN[0];
  assign bus0.mem_addr  = drvMemAddr[0];
  assign bus0.mem_wdata = drvMemWdata[0];
  assign oIfAck[0]      = bus0.if_ack;
  assign oMemAck[0]     = bus0.mem_ack;
  assign oStall[0]      = bus0.stall_req;
  assign oIfRd[0]       = bus0.if_rdata;
  assign oMemRd[0]      = bus0.mem_rdata;

  assign bus1.if_req    = drvIfReq[1];
  assign bus1.if_addr   = drvIfAddr[1];
  assign bus1.mem_req   = drvMemReq[1];
  assign bus1.mem_we_n  = drvMemWeN[1];
  assign bus1.mem_be_n  = drvMemBeN[1];
  assign bus1.mem_addr  = drvMemAddr[1];
  assign bus1.mem_wdata = drvMemWdata[1];
  assign oIfAck[1]      = bus1.if_ack;
  assign oMemAck[1]     = bus1.mem_ack;
  assign oStall[1]      = bus1.stall_req;
  assign oIfRd[1]       = bus1.if_rdata;
  assign oMemRd[1]      = bus1.mem_rdata;

  // Asynchronous SRAM: data appears only while selected and output-enabled.
  assign sramRd[0] = (!oCeN[0] && !oOeN[0]) ? sramMem[0][oAddr[0][7:0]] : 32'h0BAD_F00D;
  assign sramRd[1] = (!oCeN[1] && !oOeN[1]) ? sramMem[1][oAddr[1][7:0]] : 32'h0BAD_F00D;

  sram_bus_ctrl #(.WAIT_CYCLES(W0), .ADDR_W(20)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus0),
    .sram_addr    (oAddr[0]),
    .sram_wdata   (oWdata[0]),
    .sram_data_oe (oDoe[0]),
    .sram_rdata   (sramRd[0]),
    .sram_ce_n    (oCeN[0]),
    .sram_oe_n    (oOeN[0]),
    .sram_we_n    (oWeN[0]),
    .sram_be_n    (oBeN[0])
  );

  sram_bus_ctrl #(.WAIT_CYCLES(W1), .ADDR_W(20)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus1),
    .sram_addr    (oAddr[1]),
    .sram_wdata   (oWdata[1]),
    .sram_data_oe (oDoe[1]),
    .sram_rdata   (sramRd[1]),
    .sram_ce_n    (oCeN[1]),
    .sram_oe_n    (oOeN[1]),
    .sram_we_n    (oWeN[1]),
    .sram_be_n    (oBeN[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:22], 14'b0, 6'($urandom_range(63)), r[1:0]};
  endfunction

  task automatic newIf(input int d);
    drvIfReq[d]  = 1'b1;
    drvIfAddr[d] = randAddr();
  endtask

  task automatic newMem(input int d);
    drvMemReq[d]   = 1'b1;
    drvMemWeN[d]   = 1'($urandom_range(1));
    drvMemBeN[d]   = ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom_range(15));
    drvMemAddr[d]  = randAddr();
    drvMemWdata[d] = $urandom;
  endtask

  // Transaction-level model: a grant at cycle g occupies the SRAM for cycles
  // g+1..g+W+1, acks at g+W+2 and frees the controller at g+W+3.
  task automatic modelCheck(input int d);
    longint w;
    bit inAcc, atAck, eIf, eMem, eStall;
    w = (d == 0) ? W0 : W1;
    if (busy[d] && cyc == grantCyc[d] + w + 3) busy[d] = 1'b0;
    if (!busy[d] && (drvIfReq[d] || drvMemReq[d])) begin
      ownerMem[d] = drvMemReq[d] && (!drvIfReq[d] || !lastMem[d]);
      lastMem[d]  = ownerMem[d];
      busy[d]     = 1'b1;
      grantCyc[d] = cyc;
      if (ownerMem[d]) begin
        tWrite[d] = !drvMemWeN[d];
        tAddr[d]  = drvMemAddr[d][21:2];
        tBe[d]    = drvMemBeN[d];
        tWdata[d] = drvMemWdata[d];
      end else begin
        tWrite[d] = 1'b0;
        tAddr[d]  = drvIfAddr[d][21:2];
        tBe[d]    = 4'b0000;
      end
    end
    inAcc = busy[d] && cyc > grantCyc[d] && cyc <= grantCyc[d] + w + 1;
    atAck = busy[d] && cyc == grantCyc[d] + w + 2;
    eIf   = atAck && !ownerMem[d];
    eMem  = atAck && ownerMem[d];
    if (atAck) begin
      if (tWrite[d]) begin
        for (int b = 0; b < 4; b++)
          if (!tBe[d][b]) refMem[d][tAddr[d][7:0]][8*b +: 8] = tWdata[d][8*b +: 8];
      end else if (ownerMem[d]) begin
        eMemRd[d] = refMem[d][tAddr[d][7:0]];
      end else begin
        eIfRd[d] = refMem[d][tAddr[d][7:0]];
      end
    end
    eStall = (drvMemReq[d] && !eMem) || (drvIfReq[d] && !eIf);
    seenIfAck[d]  = eIf;
    seenMemAck[d] = eMem;
    checkOutput($sformatf("d%0d if_ack", d), oIfAck[d], eIf);
    checkOutput($sformatf("d%0d mem_ack", d), oMemAck[d], eMem);
    checkOutput($sformatf("d%0d stall_req", d), oStall[d], eStall);
    checkOutput($sformatf("d%0d if_rdata", d), oIfRd[d], eIfRd[d]);
    checkOutput($sformatf("d%0d mem_rdata", d), oMemRd[d], eMemRd[d]);
    checkOutput($sformatf("d%0d ce_n", d), oCeN[d], !inAcc);
    checkOutput($sformatf("d%0d oe_n", d), oOeN[d], !(inAcc && !tWrite[d]));
    checkOutput($sformatf("d%0d we_n", d), oWeN[d],
                !(inAcc && tWrite[d] && cyc != grantCyc[d] + w + 1));
    checkOutput($sformatf("d%0d data_oe", d), oDoe[d], inAcc && tWrite[d]);
    checkOutput($sformatf("d%0d be_n", d), oBeN[d], inAcc ? tBe[d] : 4'hF);
    if (inAcc) begin
      checkOutput($sformatf("d%0d sram_addr", d), oAddr[d], tAddr[d]);
      if (tWrite[d]) checkOutput($sformatf("d%0d sram_wdata", d), oWdata[d], tWdata[d]);
    end
  endtask

  // Under continuous contention grants alternate MEM, IF, ... every W+3 cycles.
  task automatic checkContention(input int d);
    longint w;
    w = (d == 0) ? W0 : W1;
    if (oIfAck[d] || oMemAck[d]) begin
      checkOutput($sformatf("d%0d contend order", d), oMemAck[d], (nAck[d] % 2) == 0);
      if (nAck[d] > 0)
        checkOutput($sformatf("d%0d contend gap", d), cyc - lastAckCyc[d], w + 3);
      lastAckCyc[d] = cyc;
      nAck[d]++;
    end
  endtask

  task automatic sramWrite(input int d);
    if (!oCeN[d] && !oWeN[d])
      for (int b = 0; b < 4; b++)
        if (!oBeN[d][b]) sramMem[d][oAddr[d][7:0]][8*b +: 8] = oWdata[d][8*b +: 8];
  endtask

  task automatic applyStimulus(input int d);
    if (drvIfReq[d] && seenIfAck[d]) begin
      drvIfReq[d] = 1'b0;
      if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) newIf(d);
    end else if (drvIfReq[d]) begin
      if (mode == 1 && $urandom_range(31) == 0) drvIfReq[d] = 1'b0;
    end else if (mode == 2 || (mode == 1 && $urandom_range(2) == 0)) begin
      newIf(d);
    end
    if (drvMemReq[d] && seenMemAck[d]) begin
      drvMemReq[d] = 1'b0;
      if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) newMem(d);
    end else if (drvMemReq[d]) begin
      if (mode == 1 && $urandom_range(31) == 0) drvMemReq[d] = 1'b0;
    end else if (mode == 2 || (mode == 1 && $urandom_range(2) == 0)) begin
      newMem(d);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      modelCheck(d);
      if (contend) checkContention(d);
      if (oIfAck[d]) ifAckCnt[d]++;
      if (oMemAck[d]) memAckCnt[d]++;
      sramWrite(d);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) applyStimulus(d);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic doReset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 2; d++) begin
        drvIfReq[d]    = 1'($urandom_range(1));
        drvIfAddr[d]   = $urandom;
        drvMemReq[d]   = 1'($urandom_range(1));
        drvMemWeN[d]   = 1'($urandom_range(1));
        drvMemBeN[d]   = 4'($urandom_range(15));
        drvMemAddr[d]  = $urandom;
        drvMemWdata[d] = $urandom;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d rst ce_n", d), oCeN[d], 1'b1);
        checkOutput($sformatf("d%0d rst oe_n", d), oOeN[d], 1'b1);
        checkOutput($sformatf("d%0d rst we_n", d), oWeN[d], 1'b1);
        checkOutput($sformatf("d%0d rst be_n", d), oBeN[d], 4'hF);
        checkOutput($sformatf("d%0d rst data_oe", d), oDoe[d], 1'b0);
        checkOutput($sformatf("d%0d rst if_ack", d), oIfAck[d], 1'b0);
        checkOutput($sformatf("d%0d rst mem_ack", d), oMemAck[d], 1'b0);
        checkOutput($sformatf("d%0d rst stall", d), oStall[d], 1'b0);
        checkOutput($sformatf("d%0d rst addr", d), oAddr[d], 20'd0);
        checkOutput($sformatf("d%0d rst wdata", d), oWdata[d], 32'd0);
        checkOutput($sformatf("d%0d rst if_rdata", d), oIfRd[d], 32'd0);
        checkOutput($sformatf("d%0d rst mem_rdata", d), oMemRd[d], 32'd0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int d = 0; d < 2; d++) begin
      drvIfReq[d]  = 1'b0;
      drvMemReq[d] = 1'b0;
      busy[d]      = 1'b0;
      lastMem[d]   = 1'b0;
      eIfRd[d]     = 32'd0;
      eMemRd[d]    = 32'd0;
    end
    rst = 1'b1;
  endtask

  initial begin
    int before0, before1;
    logic [31:0] savedRd, v;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ifAckCnt[d] = 0;
      memAckCnt[d] = 0;
      nAck[d] = 0;
      lastAckCyc[d] = 0;
      seenIfAck[d] = 1'b0;
      seenMemAck[d] = 1'b0;
      for (int i = 0; i < 256; i++) begin
        v = $urandom;
        sramMem[d][i] = v;
        refMem[d][i]  = v;
      end
    end
    sramMem[0][4] = 32'h2402_0005;
    refMem[0][4]  = 32'h2402_0005;

    doReset(4);

    // Fetch of word 4 on the W=1 instance; W=3 load withdrawn mid-access.
    mode = 0;
    drvIfReq[0]   = 1'b1;
    drvIfAddr[0]  = 32'h0000_0010;
    drvMemReq[1]  = 1'b1;
    drvMemWeN[1]  = 1'b1;
    drvMemBeN[1]  = 4'b0000;
    drvMemAddr[1] = randAddr();
    before0 = ifAckCnt[0];
    before1 = memAckCnt[1];
    runCycles(2);
    drvMemReq[1] = 1'b0;
    runCycles(6);
    checkOutput("fetch rdata", oIfRd[0], 32'h2402_0005);
    checkOutput("fetch ack count", ifAckCnt[0] - before0, 1);
    checkOutput("withdraw ack count", memAckCnt[1] - before1, 1);

    // Byte store to 0x104 on the W=1 instance.
    savedRd = eMemRd[0];
    drvMemReq[0]   = 1'b1;
    drvMemWeN[0]   = 1'b0;
    drvMemBeN[0]   = 4'b1110;
    drvMemAddr[0]  = 32'h0000_0104;
    drvMemWdata[0] = 32'h0000_00AB;
    runCycles(6);
    checkOutput("store lane0", sramMem[0][65][7:0], 8'hAB);
    checkOutput("store rdata kept", oMemRd[0], savedRd);

    before0 = ifAckCnt[0] + memAckCnt[0];
    before1 = ifAckCnt[1] + memAckCnt[1];
    runCycles(10);
    checkOutput("idle acks d0", ifAckCnt[0] + memAckCnt[0] - before0, 0);
    checkOutput("idle acks d1", ifAckCnt[1] + memAckCnt[1] - before1, 0);

    // Reset asserted in the first ACCESS cycle of a write.
    drvMemReq[0]   = 1'b1;
    drvMemWeN[0]   = 1'b0;
    drvMemBeN[0]   = 4'b0011;
    drvMemAddr[0]  = randAddr();
    drvMemWdata[0] = $urandom;
    stepCycle();
    checkOutput("pre-reset we_n", oWeN[0], 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("mid-reset we_n", oWeN[0], 1'b1);
    checkOutput("mid-reset data_oe", oDoe[0], 1'b0);
    checkOutput("mid-reset ce_n", oCeN[0], 1'b1);
    doReset(3);

    // Both ports request continuously.
    for (int d = 0; d < 2; d++) begin
      newIf(d);
      newMem(d);
      nAck[d] = 0;
    end
    contend = 1'b1;
    mode = 2;
    runCycles(40);
    contend = 1'b0;
    mode = 0;
    runCycles(20);
    checkOutput("contend acks d0", nAck[0] >= 9, 1'b1);
    checkOutput("contend acks d1", nAck[1] >= 6, 1'b1);

    mode = 1;
    runCycles(1500);
    mode = 0;
    runCycles(30);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        checkOutput($sformatf("d%0d mem word %0d", d, i), sramMem[d][i], refMem[d][i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
